// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the burst master.
// Cycle-type codes, burst-type extension and FSM state encoding.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    BEAT,
    WDATA_WAIT,
    RETRY,
    DONE
  } state_e;

endpackage

// File: rtl/wishbone_burst_master_if.sv
// Core-side request/stream signals and Wishbone bus signals of the burst master.
// The master modport is the DUT view; the slave modport is the environment view.
interface wishbone_burst_master_if #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int LENW    = 4,
  parameter int TAGSIZE = 2
);
  localparam int SELW = DW / 8;

  logic               req_valid_i;
  logic               req_ready_o;
  logic [AW-1:0]      req_addr_i;
  logic               req_we_i;
  logic [SELW-1:0]    req_sel_i;
  logic [LENW-1:0]    req_len_i;
  logic [TAGSIZE-1:0] req_tag_i;
  logic [DW-1:0]      wdata_i;
  logic               wdata_valid_i;
  logic               wdata_ready_o;
  logic [DW-1:0]      rdata_o;
  logic [TAGSIZE-1:0] rdata_tag_o;
  logic               rdata_valid_o;
  logic               done_o;
  logic               err_o;
  logic [AW-1:0]      wb_adr_o;
  logic [DW-1:0]      wb_dat_o;
  logic [DW-1:0]      wb_dat_i;
  logic [SELW-1:0]    wb_sel_o;
  logic               wb_we_o;
  logic               wb_cyc_o;
  logic               wb_stb_o;
  logic [2:0]         wb_cti_o;
  logic [1:0]         wb_bte_o;
  logic               wb_lock_o;
  logic [TAGSIZE-1:0] wb_tga_o;
  logic [TAGSIZE-1:0] wb_tgc_o;
  logic [TAGSIZE-1:0] wb_tgd_o;
  logic [TAGSIZE-1:0] wb_tgd_i;
  logic               wb_ack_i;
  logic               wb_err_i;
  logic               wb_rty_i;
  logic               wb_gnt_i;

  modport master (
    input  req_valid_i, req_addr_i, req_we_i, req_sel_i,
    input  req_len_i, req_tag_i, wdata_i, wdata_valid_i,
    input  wb_dat_i, wb_tgd_i, wb_ack_i, wb_err_i,
    input  wb_rty_i, wb_gnt_i,
    output req_ready_o, wdata_ready_o, rdata_o, rdata_tag_o,
    output rdata_valid_o, done_o, err_o,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
    output wb_stb_o, wb_cti_o, wb_bte_o, wb_lock_o,
    output wb_tga_o, wb_tgc_o, wb_tgd_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_we_i, req_sel_i,
    output req_len_i, req_tag_i, wdata_i, wdata_valid_i,
    output wb_dat_i, wb_tgd_i, wb_ack_i, wb_err_i,
    output wb_rty_i, wb_gnt_i,
    input  req_ready_o, wdata_ready_o, rdata_o, rdata_tag_o,
    input  rdata_valid_o, done_o, err_o,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o,
    input  wb_stb_o, wb_cti_o, wb_bte_o, wb_lock_o,
    input  wb_tga_o, wb_tgc_o, wb_tgd_o
  );

endinterface

// File: rtl/wishbone_burst_master.sv
// Wishbone B4 registered-feedback master: single and incrementing bursts,
// with per-beat retry limit, error abort and streamed write/read data.
module wishbone_burst_master #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MAX_BURST = 16,
  parameter int LENW      = $clog2(MAX_BURST),
  parameter int TAGSIZE   = 2,
  parameter int MAX_RETRY = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  wishbone_burst_master_if.master bus
);
  import wb_pkg::*;

  localparam int SELW = DW / 8;
  localparam int OFFW = $clog2(SELW);
  localparam int RW   = $clog2(MAX_RETRY + 1);

  state_e             state_q, state_n;
  logic [AW-1:0]      addr_q, addr_n;
  logic               we_q, we_n;
  logic [SELW-1:0]    sel_q, sel_n;
  logic [LENW-1:0]    len_q, len_n;
  logic [LENW-1:0]    beat_q, beat_n;
  logic [TAGSIZE-1:0] tag_q, tag_n;
  logic [RW-1:0]      rty_q, rty_n;
  logic               errf_q, errf_n;
  logic               take_w, rd_beat, cyc_n;

  logic               ready_q, cyc_q, stb_q, lock_q, wbwe_q;
  logic               done_q, err_q, rvalid_q;
  logic [AW-1:0]      adr_q;
  logic [DW-1:0]      dat_q, rdata_q;
  logic [SELW-1:0]    wbsel_q;
  logic [2:0]         cti_q;
  logic [TAGSIZE-1:0] wbtag_q, rtag_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    addr_n  = addr_q;
    we_n    = we_q;
    sel_n   = sel_q;
    len_n   = len_q;
    beat_n  = beat_q;
    tag_n   = tag_q;
    rty_n   = rty_q;
    errf_n  = errf_q;
    take_w  = 1'b0;
    rd_beat = 1'b0;
    unique case (state_q)
      IDLE: if (bus.req_valid_i && ready_q) begin
        addr_n  = bus.req_addr_i;
        we_n    = bus.req_we_i;
        sel_n   = bus.req_sel_i;
        len_n   = bus.req_len_i;
        tag_n   = bus.req_tag_i;
        beat_n  = '0;
        rty_n   = '0;
        errf_n  = 1'b0;
        state_n = ARB;
      end
      ARB: if (bus.wb_gnt_i) begin
        if (we_q && !bus.wdata_valid_i) begin
          state_n = WDATA_WAIT;
        end else begin
          take_w  = we_q;
          state_n = BEAT;
        end
      end
      BEAT: begin
        if (bus.wb_err_i) begin
          errf_n  = 1'b1;
          state_n = DONE;
        end else if (bus.wb_rty_i) begin
          if (rty_q == RW'(MAX_RETRY)) begin
            errf_n  = 1'b1;
            state_n = DONE;
          end else begin
            rty_n   = rty_q + RW'(1);
            state_n = RETRY;
          end
        end else if (bus.wb_ack_i) begin
          rty_n   = '0;
          rd_beat = !we_q;
          if (beat_q == len_q) begin
            state_n = DONE;
          end else begin
            beat_n = beat_q + LENW'(1);
            if (we_q) begin
              if (bus.wdata_valid_i) take_w = 1'b1;
              else                   state_n = WDATA_WAIT;
            end
          end
        end
      end
      WDATA_WAIT: if (bus.wdata_valid_i) begin
        take_w  = 1'b1;
        state_n = BEAT;
      end
      RETRY:   state_n = BEAT;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    cyc_n = (state_n != IDLE) && (state_n != DONE);
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      tag_q    <= '0;
      rty_q    <= '0;
      errf_q   <= 1'b0;
      ready_q  <= 1'b0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      lock_q   <= 1'b0;
      wbwe_q   <= 1'b0;
      adr_q    <= '0;
      cti_q    <= CTI_CLASSIC;
      wbsel_q  <= '0;
      wbtag_q  <= '0;
      dat_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rtag_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_n;
      we_q     <= we_n;
      sel_q    <= sel_n;
      len_q    <= len_n;
      beat_q   <= beat_n;
      tag_q    <= tag_n;
      rty_q    <= rty_n;
      errf_q   <= errf_n;
      ready_q  <= state_n == IDLE;
      cyc_q    <= cyc_n;
      stb_q    <= state_n == BEAT;
      lock_q   <= cyc_n && (len_n != '0);
      wbwe_q   <= cyc_n && we_n;
      adr_q    <= cyc_n ? addr_n + (AW'(beat_n) << OFFW) : '0;
      cti_q    <= (!cyc_n || len_n == '0) ? CTI_CLASSIC :
                  (beat_n == len_n) ? CTI_EOB : CTI_INCR;
      wbsel_q  <= cyc_n ? sel_n : '0;
      wbtag_q  <= cyc_n ? tag_n : '0;
      if (take_w) dat_q <= bus.wdata_i;
      rvalid_q <= rd_beat;
      if (rd_beat) begin
        rdata_q <= bus.wb_dat_i;
        rtag_q  <= bus.wb_tgd_i;
      end
      done_q   <= state_n == DONE;
      err_q    <= (state_n == DONE) && errf_n;
    end
  end

  assign bus.req_ready_o   = ready_q;
  assign bus.wdata_ready_o = take_w;
  assign bus.rdata_o       = rdata_q;
  assign bus.rdata_tag_o   = rtag_q;
  assign bus.rdata_valid_o = rvalid_q;
  assign bus.done_o        = done_q;
  assign bus.err_o         = err_q;
  assign bus.wb_adr_o      = adr_q;
  assign bus.wb_dat_o      = dat_q;
  assign bus.wb_sel_o      = wbsel_q;
  assign bus.wb_we_o       = wbwe_q;
  assign bus.wb_cyc_o      = cyc_q;
  assign bus.wb_stb_o      = stb_q;
  assign bus.wb_cti_o      = cti_q;
  assign bus.wb_bte_o      = BTE_LINEAR;
  assign bus.wb_lock_o     = lock_q;
  assign bus.wb_tga_o      = wbtag_q;
  assign bus.wb_tgc_o      = wbtag_q;
  assign bus.wb_tgd_o      = wbtag_q;

endmodule

// File: tb/tb_wishbone_burst_master.sv
// Directed self-checking bench for wishbone_burst_master.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_wishbone_burst_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wishbone_burst_master_if #(
    .DW(32), .AW(32), .LENW(4), .TAGSIZE(2)
  ) bus ();

  wishbone_burst_master #(
    .DW(32), .AW(32), .MAX_BURST(16), .LENW(4),
    .TAGSIZE(2), .MAX_RETRY(3)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i   = 1'b0;
    bus.req_addr_i    = '0;
    bus.req_we_i      = 1'b0;
    bus.req_sel_i     = '0;
    bus.req_len_i     = '0;
    bus.req_tag_i     = '0;
    bus.wdata_i       = '0;
    bus.wdata_valid_i = 1'b0;
    bus.wb_dat_i      = '0;
    bus.wb_tgd_i      = '0;
    bus.wb_ack_i      = 1'b0;
    bus.wb_err_i      = 1'b0;
    bus.wb_rty_i      = 1'b0;
    bus.wb_gnt_i      = 1'b0;
  endtask

  task automatic request(input logic [31:0] a, input logic we,
                         input logic [3:0] len, input logic [1:0] tag);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = a;
    bus.req_we_i    = we;
    bus.req_sel_i   = 4'hF;
    bus.req_len_i   = len;
    bus.req_tag_i   = tag;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.wb_cyc_o, bus.wb_stb_o, bus.done_o,
         bus.rdata_valid_o, bus.wb_lock_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outs got %b want 000000",
               {bus.req_ready_o, bus.wb_cyc_o, bus.wb_stb_o,
                bus.done_o, bus.rdata_valid_o, bus.wb_lock_o});
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", bus.req_ready_o);
    end
  endtask

  task automatic test_single_read();
    request(32'h100, 1'b0, 4'd0, 2'b01);
    bus.wb_gnt_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.req_ready_o} !== 3'b100) begin
      errors++;
      $display("FAIL rd_arb cyc/stb/rdy got %b want 100",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.req_ready_o});
    end
    tick();
    checks++;
    if ({bus.wb_stb_o, bus.wb_adr_o, bus.wb_cti_o, bus.wb_lock_o,
         bus.wb_tga_o} !== {1'b1, 32'h100, 3'b000, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL rd_beat stb=%b adr=%h cti=%b lock=%b tga=%b want 1 100 000 0 01",
               bus.wb_stb_o, bus.wb_adr_o, bus.wb_cti_o, bus.wb_lock_o,
               bus.wb_tga_o);
    end
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hDEADBEEF;
    bus.wb_tgd_i = 2'b10;
    tick();
    bus.wb_ack_i = 1'b0;
    checks++;
    if ({bus.rdata_valid_o, bus.rdata_o, bus.rdata_tag_o} !==
        {1'b1, 32'hDEADBEEF, 2'b10}) begin
      errors++;
      $display("FAIL rd_data valid=%b data=%h tag=%b want 1 deadbeef 10",
               bus.rdata_valid_o, bus.rdata_o, bus.rdata_tag_o);
    end
    checks++;
    if ({bus.done_o, bus.err_o, bus.wb_cyc_o} !== 3'b100) begin
      errors++;
      $display("FAIL rd_done done/err/cyc got %b want 100",
               {bus.done_o, bus.err_o, bus.wb_cyc_o});
    end
    tick();
    checks++;
    if ({bus.req_ready_o, bus.done_o, bus.rdata_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL rd_idle rdy/done/rv got %b want 100",
               {bus.req_ready_o, bus.done_o, bus.rdata_valid_o});
    end
  endtask

  task automatic test_burst_write();
    logic [2:0] cti;
    request(32'h200, 1'b1, 4'd3, 2'b11);
    bus.wdata_i       = 32'd1;
    bus.wdata_valid_i = 1'b1;
    bus.wb_gnt_i      = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_lock_o, bus.wdata_ready_o}
        !== 4'b1011) begin
      errors++;
      $display("FAIL wr_arb cyc/stb/lock/wrdy got %b want 1011",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_lock_o,
                bus.wdata_ready_o});
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      cti = (i == 3) ? 3'b111 : 3'b010;
      checks++;
      if ({bus.wb_stb_o, bus.wb_lock_o, bus.wb_we_o, bus.wb_adr_o,
           bus.wb_cti_o, bus.wb_dat_o} !==
          {3'b111, 32'h200 + 32'(4 * i), cti, 32'(i + 1)}) begin
        errors++;
        $display("FAIL wr_beat%0d stb/lock/we=%b adr=%h cti=%b dat=%h",
                 i, {bus.wb_stb_o, bus.wb_lock_o, bus.wb_we_o},
                 bus.wb_adr_o, bus.wb_cti_o, bus.wb_dat_o);
      end
      bus.wb_ack_i      = 1'b1;
      bus.wdata_i       = 32'(i + 2);
      bus.wdata_valid_i = (i < 3);
      #1;
      checks++;
      if (bus.wdata_ready_o !== (i < 3)) begin
        errors++;
        $display("FAIL wr_wrdy%0d got %b want %b", i,
                 bus.wdata_ready_o, (i < 3));
      end
    end
    tick();
    bus.wb_ack_i      = 1'b0;
    bus.wdata_valid_i = 1'b0;
    checks++;
    if ({bus.done_o, bus.err_o, bus.wb_cyc_o, bus.wb_stb_o,
         bus.wb_lock_o} !== 5'b10000) begin
      errors++;
      $display("FAIL wr_done done/err/cyc/stb/lock got %b want 10000",
               {bus.done_o, bus.err_o, bus.wb_cyc_o, bus.wb_stb_o,
                bus.wb_lock_o});
    end
    tick();
  endtask

  task automatic test_wdata_gap();
    request(32'h300, 1'b1, 4'd3, 2'b00);
    bus.wdata_i       = 32'hA0;
    bus.wdata_valid_i = 1'b1;
    bus.wb_gnt_i      = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({bus.wb_stb_o, bus.wb_adr_o, bus.wb_dat_o} !==
          {1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i)}) begin
        errors++;
        $display("FAIL gap_beat%0d stb=%b adr=%h dat=%h", i,
                 bus.wb_stb_o, bus.wb_adr_o, bus.wb_dat_o);
      end
      bus.wb_ack_i      = 1'b1;
      bus.wdata_i       = 32'hA1;
      bus.wdata_valid_i = (i == 0);
    end
    for (int w = 0; w < 2; w++) begin
      tick();
      bus.wb_ack_i = 1'b0;
      checks++;
      if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_lock_o} !== 3'b101) begin
        errors++;
        $display("FAIL gap_wait%0d cyc/stb/lock got %b want 101", w,
                 {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_lock_o});
      end
    end
    bus.wdata_i       = 32'hA2;
    bus.wdata_valid_i = 1'b1;
    #1;
    checks++;
    if (bus.wdata_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL gap_wrdy got %b want 1", bus.wdata_ready_o);
    end
    for (int i = 2; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.wb_stb_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_cti_o} !==
          {1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i),
           (i == 3) ? 3'b111 : 3'b010}) begin
        errors++;
        $display("FAIL gap_beat%0d stb=%b adr=%h dat=%h cti=%b", i,
                 bus.wb_stb_o, bus.wb_adr_o, bus.wb_dat_o, bus.wb_cti_o);
      end
      bus.wb_ack_i      = 1'b1;
      bus.wdata_i       = 32'hA3;
      bus.wdata_valid_i = (i == 2);
    end
    tick();
    bus.wb_ack_i = 1'b0;
    checks++;
    if ({bus.done_o, bus.err_o} !== 2'b10) begin
      errors++;
      $display("FAIL gap_done done/err got %b want 10",
               {bus.done_o, bus.err_o});
    end
    tick();
  endtask

  task automatic test_retry();
    request(32'h400, 1'b0, 4'd3, 2'b00);
    bus.wb_gnt_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h40;
    tick();
    bus.wb_dat_i = 32'h41;
    tick();
    bus.wb_ack_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      checks++;
      if ({bus.wb_stb_o, bus.wb_adr_o} !== {1'b1, 32'h408}) begin
        errors++;
        $display("FAIL rty_issue%0d stb=%b adr=%h want 1 408", r,
                 bus.wb_stb_o, bus.wb_adr_o);
      end
      bus.wb_rty_i = 1'b1;
      tick();
      bus.wb_rty_i = 1'b0;
      checks++;
      if ({bus.wb_cyc_o, bus.wb_stb_o} !== 2'b10) begin
        errors++;
        $display("FAIL rty_gap%0d cyc/stb got %b want 10", r,
                 {bus.wb_cyc_o, bus.wb_stb_o});
      end
      tick();
    end
    checks++;
    if ({bus.wb_stb_o, bus.wb_adr_o} !== {1'b1, 32'h408}) begin
      errors++;
      $display("FAIL rty_reissue stb=%b adr=%h want 1 408",
               bus.wb_stb_o, bus.wb_adr_o);
    end
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h42;
    tick();
    bus.wb_dat_i = 32'h43;
    checks++;
    if ({bus.rdata_valid_o, bus.rdata_o, bus.wb_adr_o, bus.wb_cti_o} !==
        {1'b1, 32'h42, 32'h40C, 3'b111}) begin
      errors++;
      $display("FAIL rty_data rv=%b data=%h adr=%h cti=%b",
               bus.rdata_valid_o, bus.rdata_o, bus.wb_adr_o, bus.wb_cti_o);
    end
    tick();
    bus.wb_ack_i = 1'b0;
    checks++;
    if ({bus.done_o, bus.err_o} !== 2'b10) begin
      errors++;
      $display("FAIL rty_done done/err got %b want 10",
               {bus.done_o, bus.err_o});
    end
    tick();
  endtask

  task automatic test_retry_abort();
    request(32'h500, 1'b0, 4'd0, 2'b00);
    bus.wb_gnt_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) begin
      checks++;
      if ({bus.wb_stb_o, bus.wb_adr_o} !== {1'b1, 32'h500}) begin
        errors++;
        $display("FAIL abort_issue%0d stb=%b adr=%h want 1 500", r,
                 bus.wb_stb_o, bus.wb_adr_o);
      end
      bus.wb_rty_i = 1'b1;
      tick();
      bus.wb_rty_i = 1'b0;
      if (r < 3) tick();
    end
    checks++;
    if ({bus.done_o, bus.err_o, bus.wb_cyc_o} !== 3'b110) begin
      errors++;
      $display("FAIL abort_done done/err/cyc got %b want 110",
               {bus.done_o, bus.err_o, bus.wb_cyc_o});
    end
    tick();
  endtask

  task automatic test_err_abort();
    request(32'h600, 1'b0, 4'd7, 2'b00);
    bus.wb_gnt_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h11;
    tick();
    checks++;
    if ({bus.rdata_valid_o, bus.rdata_o, bus.wb_adr_o} !==
        {1'b1, 32'h11, 32'h604}) begin
      errors++;
      $display("FAIL err_beat0 rv=%b data=%h adr=%h",
               bus.rdata_valid_o, bus.rdata_o, bus.wb_adr_o);
    end
    bus.wb_err_i = 1'b1;
    bus.wb_dat_i = 32'h22;
    tick();
    bus.wb_err_i = 1'b0;
    bus.wb_ack_i = 1'b0;
    checks++;
    if ({bus.wb_cyc_o, bus.done_o, bus.err_o, bus.rdata_valid_o} !==
        4'b0110) begin
      errors++;
      $display("FAIL err_done cyc/done/err/rv got %b want 0110",
               {bus.wb_cyc_o, bus.done_o, bus.err_o, bus.rdata_valid_o});
    end
    tick();
    checks++;
    if ({bus.wb_cyc_o, bus.rdata_valid_o, bus.done_o, bus.err_o,
         bus.req_ready_o} !== 5'b00001) begin
      errors++;
      $display("FAIL err_after cyc/rv/done/err/rdy got %b want 00001",
               {bus.wb_cyc_o, bus.rdata_valid_o, bus.done_o, bus.err_o,
                bus.req_ready_o});
    end
  endtask

  task automatic test_grant_reset();
    request(32'h700, 1'b0, 4'd3, 2'b00);
    bus.wb_gnt_i = 1'b0;
    tick();
    bus.req_valid_i = 1'b0;
    for (int w = 0; w < 5; w++) begin
      checks++;
      if ({bus.wb_cyc_o, bus.wb_stb_o} !== 2'b10) begin
        errors++;
        $display("FAIL gnt_wait%0d cyc/stb got %b want 10", w,
                 {bus.wb_cyc_o, bus.wb_stb_o});
      end
      if (w == 4) bus.wb_gnt_i = 1'b1;
      tick();
    end
    checks++;
    if (bus.wb_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL gnt_stb got %b want 1", bus.wb_stb_o);
    end
    bus.wb_ack_i = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_lock_o, bus.req_ready_o,
         bus.done_o, bus.rdata_valid_o, bus.wb_adr_o} !== 38'b0) begin
      errors++;
      $display("FAIL rst_mid flags=%b adr=%h want all zero",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_lock_o,
                bus.req_ready_o, bus.done_o, bus.rdata_valid_o},
               bus.wb_adr_o);
    end
    idle_inputs();
    tick();
    checks++;
    if ({bus.wb_cyc_o, bus.done_o, bus.req_ready_o} !== 3'b000) begin
      errors++;
      $display("FAIL rst_hold cyc/done/rdy got %b want 000",
               {bus.wb_cyc_o, bus.done_o, bus.req_ready_o});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.req_ready_o, bus.done_o, bus.wb_cyc_o} !== 3'b100) begin
      errors++;
      $display("FAIL rst_release rdy/done/cyc got %b want 100",
               {bus.req_ready_o, bus.done_o, bus.wb_cyc_o});
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_burst_write();
    test_wdata_gap();
    test_retry();
    test_retry_abort();
    test_err_abort();
    test_grant_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
